// File: rtl/dsm_pkg.sv
// dsm_pkg: widths and arithmetic helpers shared by dsm_modulator.
// DSM_SECOND_ORDER_EN selects the wider second-order accumulator width.
package dsm_pkg;
  function automatic int acc_w(input int data_w);
`ifdef DSM_SECOND_ORDER_EN
    return data_w + 4;
`else
    return data_w + 2;
`endif
  endfunction
  function automatic longint full_scale(input int data_w, input logic pos);
    return pos ? (longint'(1) <<< (data_w - 1)) : -(longint'(1) <<< (data_w - 1));
  endfunction
  function automatic longint sext(input logic [63:0] v, input int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction
endpackage

// File: rtl/dsm_tick_gen.sv
// dsm_tick_gen: clock-enable tick every CLK_DIV cycles and frame boundary every OSR ticks.
module dsm_tick_gen #(
  parameter int CLK_DIV = 2,
  parameter int OSR = 64
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick,
  output logic frame_end
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(OSR);
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign frame_end = tick && fcnt == FW'(OSR - 1);
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      fcnt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      fcnt <= frame_end ? '0 : tick ? fcnt + 1'b1 : fcnt;
    end
endmodule

// File: rtl/dsm_modulator.sv
// dsm_modulator: 1-bit delta-sigma DAC modulator with a one-deep sample buffer.
// Define DSM_SECOND_ORDER_EN for the second-order loop; default is first order.
module dsm_modulator
  import dsm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CLK_DIV = 2,
  parameter int OSR = 64
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              clr_underrun,
  output logic              dac_out,
  output logic              tick_out,
  output logic              underrun
);
  localparam int AW = acc_w(DATA_W);
  localparam logic signed [AW-1:0] FB_P = AW'(full_scale(DATA_W, 1'b1));
  localparam logic signed [AW-1:0] FB_N = AW'(full_scale(DATA_W, 1'b0));
  logic tick, frame_end, hold_full, accept;
  logic [DATA_W-1:0] hold, active;
  logic signed [AW-1:0] x, fb, e1, e_out, acc1;
  dsm_tick_gen #(.CLK_DIV(CLK_DIV), .OSR(OSR)) u_tick (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .tick(tick),
    .frame_end(frame_end)
  );
  assign s_ready = ~hold_full;
  assign accept = s_valid && s_ready;
  assign x = AW'(sext(64'(active), DATA_W));
  assign fb = dac_out ? FB_P : FB_N;
  assign e1 = acc1 + x - fb;
`ifdef DSM_SECOND_ORDER_EN
  logic signed [AW-1:0] acc2, e2;
  assign e2 = acc2 + e1 - fb;
  assign e_out = e2;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) acc2 <= '0;
    else if (tick) acc2 <= e2;
`else
  assign e_out = e1;
`endif
  // A sample accepted on a boundary cycle waits in hold for the next boundary.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold <= '0;
      active <= '0;
      underrun <= 1'b0;
      tick_out <= 1'b0;
      acc1 <= '0;
      dac_out <= 1'b0;
    end else begin
      hold_full <= accept | (hold_full & ~frame_end);
      hold <= accept ? s_data : hold;
      active <= (frame_end && hold_full) ? hold : active;
      underrun <= (frame_end && !hold_full) | (underrun & ~clr_underrun);
      tick_out <= tick;
      acc1 <= tick ? e1 : acc1;
      dac_out <= tick ? ~e_out[AW-1] : dac_out;
    end
endmodule

// File: tb/tb_dsm_modulator.sv
// tb_dsm_modulator: scoreboard plus directed and table-driven checks for dsm_modulator.
module tb_dsm_modulator;
  localparam int DW = 16, CD = 2, OS = 4;
`ifdef DSM_SECOND_ORDER_EN
  localparam int AW = DW + 4;
  localparam bit SO = 1'b1;
`else
  localparam int AW = DW + 2;
  localparam bit SO = 1'b0;
`endif
  typedef struct {
    logic [DW-1:0] x;
    int lo;
    int hi;
  } dvec_t;
  logic clk_in = 1'b0, rst_n = 1'b0, s_valid = 1'b0, clr_underrun = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, dac_out, tick_out, underrun;
  int n_cmp = 0, n_bad = 0;
  bit exp_seq[6];
  dvec_t dv[3];

  dsm_modulator #(.DATA_W(DW), .CLK_DIV(CD), .OSR(OS)) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .clr_underrun(clr_underrun),
    .dac_out(dac_out),
    .tick_out(tick_out),
    .underrun(underrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model, advanced on the same edges as the DUT
  int m_cnt = 0, m_fcnt = 0;
  bit m_hf = 0, m_dac = 0, m_ur = 0, m_tick = 0;
  logic [DW-1:0] m_hold = '0, m_act = '0;
  longint m_a1 = 0, m_a2 = 0;
  bit exp_q[$];

  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((longint'(1) << AW) - 1);
    return m[AW-1] ? m - (longint'(1) << AW) : m;
  endfunction

  function automatic bit boundary_next();
    return m_cnt == CD - 1 && m_fcnt == OS - 1;
  endfunction

  initial forever begin
    bit t, fe, acc;
    longint x, fb, e1, e2;
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_fcnt = 0; m_hf = 0; m_dac = 0; m_ur = 0; m_tick = 0;
      m_hold = '0; m_act = '0; m_a1 = 0; m_a2 = 0;
      exp_q.delete();
    end else begin
      t = m_cnt == CD - 1;
      fe = t && m_fcnt == OS - 1;
      acc = s_valid && !m_hf;
      if (t) begin
        x = longint'($signed(m_act));
        fb = m_dac ? 32768 : -32768;
        e1 = wrap(m_a1 + x - fb);
        m_a1 = e1;
        if (SO) begin
          e2 = wrap(m_a2 + e1 - fb);
          m_a2 = e2;
          m_dac = e2 >= 0;
        end else m_dac = e1 >= 0;
        exp_q.push_back(m_dac);
      end
      m_tick = t;
      m_ur = (fe && !m_hf) ? 1'b1 : clr_underrun ? 1'b0 : m_ur;
      if (fe && m_hf) begin
        m_act = m_hold;
        m_hf = 0;
      end
      if (acc) begin
        m_hold = s_data;
        m_hf = 1;
      end
      m_cnt = t ? 0 : m_cnt + 1;
      m_fcnt = fe ? 0 : t ? m_fcnt + 1 : m_fcnt;
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (rst_n) begin
      check("sb_tick_out", tick_out, m_tick);
      check("sb_s_ready", s_ready, !m_hf);
      check("sb_underrun", underrun, m_ur);
      if (tick_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_dac: tick_out with no expected bit queued");
        end else check("sb_dac", dac_out, exp_q.pop_front());
      end
    end
  end

  task automatic idle_seq(input string tag);
    int t = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (tick_out) begin
        if (t < 6) check($sformatf("%s_dac%0d", tag, t), dac_out, exp_seq[t]);
        t++;
      end
    end
    check({tag, "_ticks"}, t, 6);
  endtask

  task automatic wait_not_boundary();
    while (boundary_next()) @(negedge clk_in);
  endtask

  initial begin
    bit ok;
    int ones, n, c;
    exp_seq = SO ? '{1, 1, 0, 1, 0, 0} : '{1, 1, 0, 1, 0, 1};
    dv = SO ? '{'{16'd8192, 39, 41}, '{16'd0, 30, 34}, '{16'hE000, 22, 26}}
            : '{'{16'd16384, 48, 48}, '{16'd0, 32, 32}, '{16'd8192, 40, 40}};
    repeat (3) @(negedge clk_in);
    check("rst_dac_out", dac_out, 0);
    check("rst_tick_out", tick_out, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    idle_seq("idle");
    check("idle_underrun", underrun, 1);
    // plain clear
    wait_not_boundary();
    clr_underrun = 1'b1;
    @(negedge clk_in);
    clr_underrun = 1'b0;
    check("clr_underrun", underrun, 0);
    // clear on the same cycle as an underrun: set wins
    ok = 0;
    for (c = 0; c < 40 && !ok; c++) begin
      @(negedge clk_in);
      ok = boundary_next();
    end
    check("find_boundary", ok, 1);
    clr_underrun = 1'b1;
    @(negedge clk_in);
    clr_underrun = 1'b0;
    check("clr_vs_set", underrun, 1);
    wait_not_boundary();
    clr_underrun = 1'b1;
    @(negedge clk_in);
    clr_underrun = 1'b0;
    check("clr_again", underrun, 0);
    // back-to-back samples
    wait_not_boundary();
    check("b2b_ready0", s_ready, 1);
    s_valid = 1'b1;
    s_data = 16'h1000;
    @(negedge clk_in);
    check("b2b_busy", s_ready, 0);
    s_data = 16'h2000;
    c = 0;
    while (!s_ready && c < 20) begin
      @(negedge clk_in);
      c++;
    end
    check("b2b_reopen", s_ready, 1);
    check("b2b_wait_bound", c <= OS * CD, 1);
    @(negedge clk_in);
    s_valid = 1'b0;
    check("b2b_second_taken", s_ready, 0);
    c = 0;
    while (!s_ready && c < 20) begin
      @(negedge clk_in);
      c++;
    end
    check("b2b_second_loaded", s_ready, 1);
    check("b2b_no_underrun", underrun, 0);
    // density vectors
    for (int i = 0; i < 3; i++) begin
      s_data = dv[i].x;
      s_valid = 1'b1;
      repeat (80) @(negedge clk_in);
      ones = 0;
      n = 0;
      for (c = 0; c < 400 && n < 64; c++) begin
        @(negedge clk_in);
        if (tick_out) begin
          n++;
          ones += int'(dac_out);
        end
      end
      check($sformatf("density%0d_ticks", i), n, 64);
      n_cmp++;
      if (ones < dv[i].lo || ones > dv[i].hi) begin
        n_bad++;
        $display("FAIL density%0d: got %0d ones expected %0d..%0d", i, ones, dv[i].lo, dv[i].hi);
      end
    end
    s_valid = 1'b0;
    // asynchronous reset mid-frame while dac_out is high
    ok = 0;
    for (c = 0; c < 40 && !ok; c++) begin
      @(negedge clk_in);
      ok = dac_out;
    end
    check("find_dac_high", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_dac_out", dac_out, 0);
    check("async_tick_out", tick_out, 0);
    check("async_s_ready", s_ready, 1);
    check("async_underrun", underrun, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    idle_seq("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dsm_modulator.md
# dsm_modulator

Oversampling delta-sigma modulator stage of the DAC path, directly downstream of the sample source and the clock-rate divider. It accepts signed PCM samples over a valid/ready handshake and emits a 1-bit density-modulated stream. Conversion is paced by an internal clock-enable tick that replaces a divided clock, so the whole block runs in one clock domain. The single output bit drives the pin/RC filter.

## Interface
- `DATA_W`, 16: PCM sample width, signed two's complement.
- `CLK_DIV`, 2: `clk_in` cycles per modulator tick; must be ≥1.
- `OSR`, 64: modulator ticks per input sample (frame length); must be ≥2.
- `clk_in`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_W  signed PCM sample.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  holding register empty; a transfer occurs when `s_valid && s_ready`.
- `clr_underrun`  in  1  synchronous clear of `underrun`.
- `dac_out`  out  1  modulated bitstream, registered.
- `tick_out`  out  1  one-cycle pulse marking each `dac_out` update.
- `underrun`  out  1  sticky flag: a frame boundary found no sample waiting.

## Operation
- Reset values: `dac_out`=0, `tick_out`=0, `underrun`=0, `s_ready`=1. All counters, accumulators, the holding register and the active sample are cleared to 0.
- Tick counter `cnt` runs 0..CLK_DIV-1 and wraps to 0. Tick is true when `cnt`==CLK_DIV-1. With CLK_DIV=1, tick is true every cycle.
- Frame counter runs 0..OSR-1 and advances only on tick. The frame boundary is a tick with frame count ==OSR-1.
- Input buffer has one entry:
  - `s_ready` = ~hold_full.
  - An accepted transfer sets hold_full and stores `s_data`.
- At a frame boundary:
  - If hold_full: active ← hold and hold_full ← 0.
  - Otherwise active keeps its previous value and `underrun` ← 1.
  - A transfer accepted in the same cycle as the boundary fills hold but is not loaded until the next boundary. The boundary still counts as an underrun.
- Clearing `underrun`: `clr_underrun` clears it, except when an underrun occurs in the same cycle, in which case set wins.
- Feedback: fb = `dac_out` ? +2^(DATA_W-1) : −2^(DATA_W-1).
- First order (accumulator width DATA_W+2), on each tick:
  - e = acc1 + x − fb, where x is the active sample sign-extended.
  - acc1 ← e.
  - `dac_out` ← (e ≥ 0).
- Second order (width DATA_W+4, see Configuration), on each tick:
  - e1 = acc1 + x − fb; e2 = acc2 + e1 − fb.
  - acc1 ← e1, acc2 ← e2.
  - `dac_out` ← (e2 ≥ 0).
- Arithmetic is wrap-around two's complement with no saturation. Stability is guaranteed only for |x| ≤ 2^(DATA_W-2) in second-order mode.

## Timing
- `dac_out` and `tick_out` change on the edge at which tick was true. `tick_out` is high for exactly one cycle after that edge.
- The active sample loaded at a boundary is first used on the following tick.
- Input-to-output latency, from acceptance to first use: at most (OSR+1)·CLK_DIV cycles.
- `s_ready` deasserts on the edge after acceptance. It reasserts on the edge after the next boundary.
- Asserting `rst_n` low forces all outputs to their reset values immediately, without a clock, including mid-frame.

## Configuration
- `DSM_SECOND_ORDER_EN` defined: second-order loop with acc1/acc2 and width DATA_W+4.
- `DSM_SECOND_ORDER_EN` undefined: first-order loop with acc1 only and width DATA_W+2. acc2 is not present.
- Ports and timing are identical in both builds.

## Structure
- Package `dsm_pkg` holds:
  - the accumulator width functions `acc_w(DATA_W)`;
  - the full-scale feedback constant function;
  - the sign-extension helper.
- Sub-module `dsm_tick_gen` holds the CLK_DIV tick counter and the OSR frame counter. It outputs `tick` and `frame_end`.

## Test plan
All scenarios use DATA_W=16, CLK_DIV=2, OSR=4 unless stated.
- Reset: hold `rst_n` low → `dac_out`=0, `s_ready`=1, `underrun`=0. After release, `tick_out` pulses every 2nd cycle.
- First order, x=0 → `dac_out` sequence 1,1,0,1,0,1,0…, giving 50% ones density from the third tick on.
- First order, x=+16384 → ones density is exactly 75% over 64 ticks. Second order, x=+8192 → density is 62.5% ±1/64.
- Back-to-back `s_valid` with 0x1000 then 0x2000:
  - first is accepted, then `s_ready`=0 until the next boundary;
  - second is accepted on the cycle after the boundary;
  - `underrun` stays 0.
- No sample at a boundary → `underrun`=1 and the bitstream continues on the previous sample. Pulse `clr_underrun` → 0. Underrun and clear in the same cycle → flag stays 1.
- Assert `rst_n` mid-frame with `dac_out`=1 → `dac_out` drops to 0 before the next `clk_in` edge, and the accumulators are 0 after release.
